// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one CHUNK-bit slice per stage,
// built from 2-bit g/p cells, carry registered between stages.
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    localparam int STAGES = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NP = CHUNK / 2;
    localparam int L  = STAGES - 1;

    logic             stall;
    logic             vo_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign stall    = vo_q && !out_ready;
    assign in_ready = ~stall;

    genvar k, j;
    for (k = 0; k < STAGES; k++) begin : g_st
        // x_q carries A with already-resolved slices overwritten by sum bits;
        // b_q only keeps the B' bits not yet consumed.
        localparam int R = WIDTH - k * CHUNK;

        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] x_q;
        logic [R-1:0]     b_q;

        logic [CHUNK-1:0] p;
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] cs;
        logic [NP:0]      pc;
        logic [NP-1:0]    mc;
        logic [WIDTH-1:0] x_d;

        if (k == 0) begin : g_ld
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    x_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    v_q <= in_valid;
                    if (in_valid) begin
                        x_q <= a;
                        b_q <= sub ? ~b : b;
                        c_q <= sub | cin;
                    end
                end
            end
        end else begin : g_ld
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    x_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    v_q <= g_st[k-1].v_q;
                    if (g_st[k-1].v_q) begin
                        x_q <= g_st[k-1].x_d;
                        b_q <= g_st[k-1].b_q[R+CHUNK-1:CHUNK];
                        c_q <= g_st[k-1].pc[NP];
                    end
                end
            end
        end

        assign p     = x_q[k*CHUNK +: CHUNK] ^ b_q[CHUNK-1:0];
        assign g     = x_q[k*CHUNK +: CHUNK] & b_q[CHUNK-1:0];
        assign pc[0] = c_q;

        for (j = 0; j < NP; j++) begin : g_pair
            assign mc[j]       = g[2*j] | (p[2*j] & pc[j]);
            assign cs[2*j]     = p[2*j] ^ pc[j];
            assign cs[2*j+1]   = p[2*j+1] ^ mc[j];
            assign pc[j+1]     = g[2*j+1] | (p[2*j+1] & mc[j]);
        end

        always_comb begin
            x_d = x_q;
            x_d[k*CHUNK +: CHUNK] = cs;
        end
    end

    // mc of the top pair is the carry into bit WIDTH-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vo_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (!stall) begin
            vo_q <= g_st[L].v_q;
            if (g_st[L].v_q) begin
                sum_q  <= g_st[L].x_d;
                cout_q <= g_st[L].pc[NP];
                ovf_q  <= g_st[L].pc[NP] ^ g_st[L].mc[NP-1];
            end
        end
    end

    assign out_valid = vo_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: 32/8 directed vectors, backpressure, reset
// mid-flight, and an exhaustive 4/2 configuration under random out_ready.
module tb_cla_pipe_adder;

    localparam int W  = 32;
    localparam int C  = 8;
    localparam int ST = W / C;
    localparam int SW = 4;
    localparam int SC = 2;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct packed {
        logic [SW-1:0] sum;
        logic          cout;
        logic          ovf;
    } sres_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
    logic         out_valid, out_ready = 1'b1, cout, ovf;
    logic [W-1:0] a = '0, b = '0, sum;

    logic          s_in_valid = 1'b0, s_in_ready, s_cin = 1'b0, s_sub = 1'b0;
    logic          s_out_valid, s_out_ready = 1'b1, s_cout, s_ovf;
    logic [SW-1:0] s_a = '0, s_b = '0, s_sum;

    cla_pipe_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_pipe_adder #(.WIDTH(SW), .CHUNK(SC)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
    );

    always #5 clk = ~clk;

    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    res_t q[$];
    sres_t sq[$];

    int   n_dlv = 0, dlv_first = 0, dlv_last = 0, n_stall_rdy = 0;
    int   acc_edge = 0;
    logic stl_prev = 1'b0;
    logic [W+1:0] prev_out = '0;
    logic s_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        logic [W-1:0] yb;
        logic [W:0]   t;
        res_t         r;
        yb = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, (s ? 1'b1 : c)};
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (x[W-1] == yb[W-1]) && (t[W-1] != x[W-1]);
        return r;
    endfunction

    function automatic sres_t smodel(input logic [SW-1:0] x,
                                     input logic [SW-1:0] y,
                                     input logic c, input logic s);
        logic [SW-1:0] yb;
        logic [SW:0]   t;
        sres_t         r;
        yb = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yb} + {{SW{1'b0}}, (s ? 1'b1 : c)};
        r.sum  = t[SW-1:0];
        r.cout = t[SW];
        r.ovf  = (x[SW-1] == yb[SW-1]) && (t[SW-1] != x[SW-1]);
        return r;
    endfunction

    // Big DUT monitor: handshake rule, hold-while-stalled, scoreboard.
    always @(negedge clk) begin
        res_t e;
        if (rst_n) begin
            chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (stl_prev) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_data", {sum, cout, ovf}, prev_out);
            end
            stl_prev = out_valid && !out_ready;
            prev_out = {sum, cout, ovf};
            if (!in_ready) n_stall_rdy++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 0, 1);
                end else begin
                    e = q.pop_front();
                    chk("sum", sum, e.sum);
                    chk("cout", cout, e.cout);
                    chk("ovf", ovf, e.ovf);
                end
                if (n_dlv == 0) dlv_first = cyc;
                dlv_last = cyc;
                n_dlv++;
            end
        end else begin
            stl_prev = 1'b0;
        end
    end

    always @(negedge clk) begin
        sres_t e;
        if (rst_n && s_out_valid && s_out_ready) begin
            if (sq.size() == 0) begin
                chk("small_unexpected_beat", 0, 1);
            end else begin
                e = sq.pop_front();
                chk("small_result", {s_sum, s_cout, s_ovf}, {e.sum, e.cout, e.ovf});
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts, input res_t e);
        bit got;
        got = 0;
        in_valid = 1'b1;
        a = ta; b = tb; cin = tc; sub = ts;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        else begin
            q.push_back(e);
            acc_edge = cyc + 1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic s_send(input logic [SW-1:0] ta, input logic [SW-1:0] tb,
                          input logic tc, input logic ts);
        bit got;
        got = 0;
        s_in_valid = 1'b1;
        s_a = ta; s_b = tb; s_cin = tc; s_sub = ts;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("small_accept_timeout", 0, 1);
        else sq.push_back(smodel(ta, tb, tc, ts));
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    vec_t tbl[11];

    initial begin
        logic [W-1:0] ra, rb;
        logic rc, rs;

        tbl[0]  = '{32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[1]  = '{32'h5,        32'h7,        1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[2]  = '{32'h7,        32'h5,        1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
        tbl[3]  = '{32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[4]  = '{32'h80000000, 32'h1,        1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[5]  = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
        tbl[6]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[7]  = '{32'h0,        32'h0,        1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[8]  = '{32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0};
        tbl[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[10] = '{32'h1,        32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000002, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        foreach (tbl[i])
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                 res_t'{tbl[i].sum, tbl[i].cout, tbl[i].ovf});
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        drain();

        n_dlv = 0;
        n_stall_rdy = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(W'(i), W'(i), 1'b0, 1'b0, res_t'{W'(2 * i), 1'b0, 1'b0});
            end
            begin
                bit seen;
                seen = 0;
                for (int k = 0; k < 50; k++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) begin
                        seen = 1;
                        break;
                    end
                end
                if (!seen) chk("bp_out_valid_timeout", 0, 1);
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_stall_cycles", n_stall_rdy, 3);
        chk("bp_delivered", n_dlv, 8);
        chk("bp_no_gap", dlv_last - dlv_first, 7);

        for (int i = 0; i < 3; i++)
            send(32'h100 + W'(i), 32'h33, 1'b0, 1'b0,
                 model(32'h100 + W'(i), 32'h33, 1'b0, 1'b0));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_dlv = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_stale", n_dlv, 0);
        send(32'h1234, 32'h4321, 1'b1, 1'b0, res_t'{32'h5556, 1'b0, 1'b0});
        drain();
        chk("latency", dlv_last - acc_edge, ST);

        fork
            begin
                for (int ai = 0; ai < 16; ai++)
                    for (int bi = 0; bi < 16; bi++)
                        for (int ci = 0; ci < 2; ci++)
                            for (int si = 0; si < 2; si++)
                                s_send(SW'(ai), SW'(bi), 1'(ci), 1'(si));
                for (int k = 0; k < 400 && sq.size() != 0; k++) @(posedge clk);
                #1;
                chk("small_drain_empty", sq.size(), 0);
                s_done = 1'b1;
            end
            begin
                while (!s_done) begin
                    @(posedge clk);
                    #1;
                    s_out_ready = 1'($urandom_range(0, 1));
                end
                s_out_ready = 1'b1;
            end
        join

        chk("final_queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
